// File: rtl/cory_monitor.sv
// cory_monitor: passive observer of one valid/ready channel.
// Counts transfer/stall/idle cycles with saturating counters, tracks the data
// of the latest transfer, a wrapping sum of transferred data and the longest
// stall run, and raises sticky flags when a stalled beat is withdrawn or has
// its data changed before it is accepted. Nothing is driven onto the channel.
module cory_monitor #(
  parameter int N = 64,
  parameter int C = 32
) (
  input  logic         clk,
  input  logic         i_v,
  input  logic [N-1:0] i_d,
  input  logic         i_r,
  input  logic         reset_n,
  output logic [C-1:0] o_xfer_cnt,
  output logic [C-1:0] o_stall_cnt,
  output logic [C-1:0] o_idle_cnt,
  output logic [N-1:0] o_last_d,
  output logic [N-1:0] o_sum,
  output logic [15:0]  o_max_stall,
  output logic         o_err_drop,
  output logic         o_err_chg
);

  logic [C-1:0] xfer_q,  xfer_d;
  logic [C-1:0] stall_q, stall_d;
  logic [C-1:0] idle_q,  idle_d;
  logic [N-1:0] last_q,  last_d;
  logic [N-1:0] sum_q,   sum_d;
  logic [15:0]  max_q,   max_d;
  logic [15:0]  run_q,   run_d;
  logic         drop_q,  drop_d;
  logic         chg_q,   chg_d;
  logic         pend_q,  pend_d;
  logic [N-1:0] hold_q,  hold_d;

  // Saturating increment for the C-bit cycle counters.
  function automatic logic [C-1:0] sat_inc_c(input logic [C-1:0] v);
    return (v == {C{1'b1}}) ? v : v + C'(1);
  endfunction

  // Saturating increment for the 16-bit stall-run length.
  function automatic logic [15:0] sat_inc_16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Classify the current cycle and compute every next-state value.
  always_comb begin
    xfer_d  = xfer_q;
    stall_d = stall_q;
    idle_d  = idle_q;
    last_d  = last_q;
    sum_d   = sum_q;
    max_d   = max_q;
    run_d   = run_q;
    drop_d  = drop_q;
    chg_d   = chg_q;
    pend_d  = pend_q;
    hold_d  = hold_q;

    // A beat stalled last cycle: it must still be offered, with the same data.
    if (pend_q) begin
      if (!i_v) begin
        drop_d = 1'b1;
      end else if (i_d != hold_q) begin
        chg_d = 1'b1;
      end
    end

    if (i_v && i_r) begin
      xfer_d = sat_inc_c(xfer_q);
      last_d = i_d;
      sum_d  = sum_q + i_d;
      run_d  = 16'd0;
      pend_d = 1'b0;
    end else if (i_v) begin
      stall_d = sat_inc_c(stall_q);
      pend_d  = 1'b1;
      hold_d  = i_d;
      run_d   = sat_inc_16(run_q);
      if (run_d > max_q) begin
        max_d = run_d;
      end
    end else begin
      idle_d = sat_inc_c(idle_q);
      pend_d = 1'b0;
      run_d  = 16'd0;
    end
  end

  // State registers; asynchronous active-low reset clears everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xfer_q  <= '0;
      stall_q <= '0;
      idle_q  <= '0;
      last_q  <= '0;
      sum_q   <= '0;
      max_q   <= '0;
      run_q   <= '0;
      drop_q  <= 1'b0;
      chg_q   <= 1'b0;
      pend_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      xfer_q  <= xfer_d;
      stall_q <= stall_d;
      idle_q  <= idle_d;
      last_q  <= last_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      run_q   <= run_d;
      drop_q  <= drop_d;
      chg_q   <= chg_d;
      pend_q  <= pend_d;
      hold_q  <= hold_d;
    end
  end

  assign o_xfer_cnt  = xfer_q;
  assign o_stall_cnt = stall_q;
  assign o_idle_cnt  = idle_q;
  assign o_last_d    = last_q;
  assign o_sum       = sum_q;
  assign o_max_stall = max_q;
  assign o_err_drop  = drop_q;
  assign o_err_chg   = chg_q;

endmodule

// File: tb/tb_cory_monitor.sv
// Bench for cory_monitor: a 64-bit/32-bit-counter instance and an
// 8-bit/4-bit-counter instance watch the same channel. A cycle-level model
// (unbounded counts clamped on comparison, previous-cycle memory for the
// protocol rules) is checked against both every cycle, plus literal checks.
module tb_cory_monitor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        v_s;
  logic        r_s;
  logic [63:0] d_s;

  logic [31:0] x0, s0, i0;
  logic [63:0] l0, sum0;
  logic [15:0] mx0;
  logic        ed0, ec0;
  logic [3:0]  x1, s1, i1;
  logic [7:0]  l1, sum1;
  logic [15:0] mx1;
  logic        ed1, ec1;

  cory_monitor #(.N(64), .C(32)) dut0 (
    .clk(clk), .i_v(v_s), .i_d(d_s), .i_r(r_s), .reset_n(reset_n),
    .o_xfer_cnt(x0), .o_stall_cnt(s0), .o_idle_cnt(i0), .o_last_d(l0),
    .o_sum(sum0), .o_max_stall(mx0), .o_err_drop(ed0), .o_err_chg(ec0)
  );

  cory_monitor #(.N(8), .C(4)) dut1 (
    .clk(clk), .i_v(v_s), .i_d(d_s[7:0]), .i_r(r_s), .reset_n(reset_n),
    .o_xfer_cnt(x1), .o_stall_cnt(s1), .o_idle_cnt(i1), .o_last_d(l1),
    .o_sum(sum1), .o_max_stall(mx1), .o_err_drop(ed1), .o_err_chg(ec1)
  );

  always #5 clk = ~clk;

  // Model state
  longint      m_x, m_s, m_i, m_run, m_max;
  logic [63:0] m_last, m_sum, m_prev;
  bit          m_pend, m_drop, m_chg0, m_chg1;

  int n_chk  = 0;
  int n_fail = 0;
  int lit_id = 0;
  int lit_done = 0;

  function automatic logic [63:0] clampc(input longint v, input int c);
    logic [63:0] mx;
    mx = (64'd1 << c) - 64'd1;
    return (64'(v) > mx) ? mx : 64'(v);
  endfunction

  task automatic model_reset();
    m_x = 0; m_s = 0; m_i = 0; m_run = 0; m_max = 0;
    m_last = '0; m_sum = '0; m_prev = '0;
    m_pend = 0; m_drop = 0; m_chg0 = 0; m_chg1 = 0;
  endtask

  // One clock edge as seen by the model.
  task automatic model_step();
    if (m_pend) begin
      if (!v_s) m_drop = 1;
      else begin
        if (d_s != m_prev) m_chg0 = 1;
        if (d_s[7:0] != m_prev[7:0]) m_chg1 = 1;
      end
    end
    if (v_s && r_s) begin
      m_x++; m_last = d_s; m_sum = m_sum + d_s; m_run = 0; m_pend = 0;
    end else if (v_s) begin
      m_s++; m_run++; if (m_run > m_max) m_max = m_run;
      m_pend = 1; m_prev = d_s;
    end else begin
      m_i++; m_run = 0; m_pend = 0;
    end
  endtask

  task automatic cyc(input bit v, input logic [63:0] d, input bit r);
    v_s = v; d_s = d; r_s = r;
    @(posedge clk);
    if (reset_n) model_step();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic lit(input int k);
    lit_id = k;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic do_lit(input int k);
    case (k)
      1: begin
        chk("t1_xfer", 64'(x0), 64'd3); chk("t1_idle", 64'(i0), 64'd5);
        chk("t1_stall", 64'(s0), 64'd0); chk("t1_last", l0, 64'd3);
        chk("t1_sum", sum0, 64'd6); chk("t1_drop", 64'(ed0), 64'd0);
        chk("t1_chg", 64'(ec0), 64'd0);
      end
      2: begin
        chk("t2_stall", 64'(s0), 64'd4); chk("t2_xfer", 64'(x0), 64'd1);
        chk("t2_max", 64'(mx0), 64'd4); chk("t2_last", l0, 64'hAB);
        chk("t2_drop", 64'(ed0), 64'd0); chk("t2_chg", 64'(ec0), 64'd0);
      end
      3: begin
        chk("t3_chg", 64'(ec0), 64'd1); chk("t3_drop", 64'(ed0), 64'd0);
        chk("t3_xfer", 64'(x0), 64'd1); chk("t3_last", l0, 64'h11);
      end
      4: begin
        chk("t3_chg_sticky", 64'(ec0), 64'd1); chk("t3_xfer11", 64'(x0), 64'd11);
      end
      5: begin
        chk("t4_drop", 64'(ed0), 64'd1); chk("t4_idle", 64'(i0), 64'd1);
        chk("t4_stall", 64'(s0), 64'd1);
      end
      6: begin
        chk("rst_xfer", 64'(x0), 64'd0); chk("rst_stall", 64'(s0), 64'd0);
        chk("rst_idle", 64'(i0), 64'd0); chk("rst_last", l0, 64'd0);
        chk("rst_sum", sum0, 64'd0); chk("rst_max", 64'(mx0), 64'd0);
        chk("rst_drop", 64'(ed0), 64'd0); chk("rst_chg", 64'(ec0), 64'd0);
        chk("rst_xfer8", 64'(x1), 64'd0); chk("rst_sum8", 64'(sum1), 64'd0);
      end
      7: begin
        chk("t5_sum8", 64'(sum1), 64'h10); chk("t5_sum64", sum0, 64'h110);
      end
      8: begin
        chk("t5_idle_sat", 64'(i1), 64'd15); chk("t5_idle64", 64'(i0), 64'd20);
      end
      9: begin
        chk("t6_max", 64'(mx0), 64'd3); chk("t6_drop", 64'(ed0), 64'd0);
        chk("t6_chg", 64'(ec0), 64'd0); chk("t6_xfer", 64'(x0), 64'd2);
        chk("t6_stall", 64'(s0), 64'd5);
      end
      default: ;
    endcase
  endtask

  // Compare process: every falling edge after the first reset.
  initial begin
    #3;
    forever begin
      @(negedge clk);
      chk("xfer64", 64'(x0), clampc(m_x, 32));
      chk("stall64", 64'(s0), clampc(m_s, 32));
      chk("idle64", 64'(i0), clampc(m_i, 32));
      chk("last64", l0, m_last);
      chk("sum64", sum0, m_sum);
      chk("max64", 64'(mx0), clampc(m_max, 16));
      chk("drop64", 64'(ed0), 64'(m_drop));
      chk("chg64", 64'(ec0), 64'(m_chg0));
      chk("xfer8", 64'(x1), clampc(m_x, 4));
      chk("stall8", 64'(s1), clampc(m_s, 4));
      chk("idle8", 64'(i1), clampc(m_i, 4));
      chk("last8", 64'(l1), {56'd0, m_last[7:0]});
      chk("sum8", 64'(sum1), {56'd0, m_sum[7:0]});
      chk("max8", 64'(mx1), clampc(m_max, 16));
      chk("drop8", 64'(ed1), 64'(m_drop));
      chk("chg8", 64'(ec1), 64'(m_chg1));
      if (lit_id != lit_done) begin
        do_lit(lit_id);
        lit_done = lit_id;
      end
    end
  end

  // Stimulus
  initial begin
    bit          v, r;
    logic [63:0] d;
    int          k;
    reset_n = 1'b1; v_s = 0; r_s = 0; d_s = '0;
    model_reset();
    #2;
    do_reset();

    // Idle then three back-to-back transfers
    repeat (5) cyc(0, 64'd0, 0);
    cyc(1, 64'd1, 1); cyc(1, 64'd2, 1); cyc(1, 64'd3, 1);
    lit(1);

    // Four-cycle stall then legal accept
    do_reset();
    repeat (4) cyc(1, 64'hAB, 0);
    cyc(1, 64'hAB, 1);
    lit(2);

    // Data changed while pending, flag stays set
    do_reset();
    cyc(1, 64'h10, 0); cyc(1, 64'h10, 0); cyc(1, 64'h11, 1);
    lit(3);
    repeat (10) cyc(1, {$urandom, $urandom}, 1);
    lit(4);

    // Valid withdrawn, then reset in the middle of activity
    do_reset();
    cyc(1, 64'h5, 0); cyc(0, 64'h0, 1);
    lit(5);
    cyc(1, 64'h77, 1);
    reset_n = 1'b0;
    model_reset();
    lit(6);
    reset_n = 1'b1;

    // Sum wrap at 8 bits, idle saturation at 4-bit counters
    do_reset();
    cyc(1, 64'hF0, 1); cyc(1, 64'h20, 1);
    lit(7);
    do_reset();
    repeat (20) cyc(0, 64'h0, 1);
    lit(8);

    // Stall runs of 3 and 2, each ended by a legal transfer
    do_reset();
    repeat (3) cyc(1, 64'h42, 0);
    cyc(1, 64'h42, 1);
    repeat (2) cyc(1, 64'h43, 0);
    cyc(1, 64'h43, 1);
    lit(9);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < ((i / 250) % 2 == 0 ? 5 : 2));
      d = {$urandom, $urandom};
      if (m_pend && v) begin
        k = $urandom_range(0, 19);
        if (k < 16) d = m_prev;
        else if (k == 16) d = m_prev ^ 64'h100;
        else if (k == 17) d = m_prev ^ 64'h1;
      end
      cyc(v, d, r);
      if (i % 400 == 399) do_reset();
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
